// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add / restoring shift-subtract step per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and zero-operand multiplies skip the iteration.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        ready,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [2:0] {
        F_MUL, F_MULH, F_MULHSU, F_MULHU, F_DIV, F_DIVU, F_REM, F_REMU
    } muldiv_funct3_t;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t         r_state;
    muldiv_funct3_t r_op;
    logic           r_neg;
    logic [31:0]    r_opnd;
    logic [63:0]    r_acc;
    logic [5:0]     r_cnt;
    logic           r_ready;
    logic           r_done;
    logic [31:0]    r_result;

    logic        w_a_sgn, w_b_sgn, w_b_nz, w_neg, w_early;
    logic [31:0] w_a_mag, w_b_mag;
    logic [63:0] w_acc_init;

    // Operand conditioning at issue: magnitudes plus the sign the result must take.
    always_comb begin
        w_a_sgn = a[31] & (funct3 != F_MULHU) & (funct3 != F_DIVU) & (funct3 != F_REMU);
        w_b_sgn = b[31] & ((funct3 == F_MUL) | (funct3 == F_MULH) |
                           (funct3 == F_DIV) | (funct3 == F_REM));
        w_a_mag = w_a_sgn ? (~a + 32'd1) : a;
        w_b_mag = w_b_sgn ? (~b + 32'd1) : b;
        w_b_nz  = |b;
        // A zero divisor yields an all-ones quotient that must never be negated.
        if (!funct3[2])     w_neg = w_a_sgn ^ w_b_sgn;
        else if (funct3[1]) w_neg = w_a_sgn;
        else                w_neg = (w_a_sgn ^ w_b_sgn) & w_b_nz;
`ifdef MULDIV_EARLY_OUT_EN
        w_early = funct3[2] ? !w_b_nz : (!(|a) || !w_b_nz);
`else
        w_early = 1'b0;
`endif
        if (w_early) w_acc_init = funct3[2] ? {w_a_mag, 32'hFFFF_FFFF} : 64'd0;
        else         w_acc_init = funct3[2] ? {32'd0, w_a_mag} : {32'd0, w_b_mag};
    end

    logic [32:0] w_msum;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [63:0] w_step, w_prod;
    logic [31:0] w_hi, w_lo, w_final;

    always_comb begin
        // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
        w_msum = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opnd : 32'd0)};
        w_ge   = r_acc[63:31] >= {1'b0, r_opnd};
        w_diff = r_acc[62:31] - r_opnd;
        if (r_op[2]) w_step = w_ge ? {w_diff, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};
        else         w_step = {w_msum, r_acc[31:1]};
        w_prod = r_neg ? (~r_acc + 64'd1) : r_acc;
        w_hi   = r_neg ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
        w_lo   = r_neg ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
        case (r_op)
            F_MUL:                    w_final = w_prod[31:0];
            F_MULH, F_MULHSU, F_MULHU: w_final = w_prod[63:32];
            F_DIV, F_DIVU:            w_final = w_lo;
            default:                  w_final = w_hi;
        endcase
    end

    // DONE spans two cycles: the fix-up cycle registers the result, the next shows done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= F_MUL;
            r_neg    <= 1'b0;
            r_opnd   <= 32'd0;
            r_acc    <= 64'd0;
            r_cnt    <= 6'd0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_op    <= muldiv_funct3_t'(funct3);
                        r_neg   <= w_neg;
                        r_opnd  <= funct3[2] ? w_b_mag : w_a_mag;
                        r_acc   <= w_acc_init;
                        r_cnt   <= 6'd0;
                        r_ready <= 1'b0;
                        r_state <= w_early ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_cnt   <= 6'd0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_step;
                        if (r_cnt == 6'd31) begin
                            r_cnt   <= 6'd0;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (flush || r_done) begin
                        r_done  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_done   <= 1'b1;
                        r_result <= w_final;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready  = r_ready;
    assign done   = r_done;
    assign result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, flush, reset, flush+start.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        ready, done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b),
        .flush(flush), .ready(ready), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        start = 1'b1; funct3 = f; a = aa; b = bb;
        @(posedge clk);
        #1;
        start = 1'b0; funct3 = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    // Count edges after acceptance until done; 0 means it never arrived.
    task automatic wait_done(output int lat, output logic [31:0] res);
        lat = 0; res = 32'hDEAD_BEEF;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i; res = result;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [31:0] exp, input int exp_lat);
        int lat;
        logic [31:0] res;
        issue(f, aa, bb);
        wait_done(lat, res);
        chk({tag, "_res"}, res, exp);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
        chk({tag, "_rdy"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic no_done(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            seen = seen | done;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        run("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
        run("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run("divu",   3'd5, 32'd100,        32'd7,         32'd14,        33);
        run("remu",   3'd7, 32'd100,        32'd7,         32'd2,         33);

        // Abort after ten steps; previous result (2) must survive.
        issue(3'd0, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_ready", {31'd0, ready}, 32'd1);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_result", result, 32'd2);
        no_done("flush_nodone");
        run("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        run("divu_by0", 3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, ZLAT);
        run("remu_by0", 3'd7, 32'd5,          32'd0,         32'd5,         ZLAT);
        run("div_by0",  3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, ZLAT);
        run("rem_by0",  3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, ZLAT);
        run("mul_zero", 3'd1, 32'd0,          32'hFFFF_FFFF, 32'd0,         ZLAT);
        run("div_ovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33);
        run("rem_ovf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33);

        // Asynchronous reset mid-operation.
        issue(3'd5, 32'd100, 32'd7);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // flush beats start in the same IDLE cycle.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("fs_ready", {31'd0, ready}, 32'd1);
        no_done("fs_nodone");
        run("final_mul", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit with its own sequencing FSM. It sits beside the ALU in the execute stage. The pipeline control issues one operation through a start/ready/done handshake and holds the pipeline while the unit is busy. The unit computes all eight `muldiv_funct3_t` operations (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) with a shared 64-bit shift datapath, one bit per cycle.

## Interface
Parameters:
- none. Width is fixed at 32 (`rv32i_word`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  issue request; sampled only when `ready`=1.
- `funct3`  in  3  operation, `muldiv_funct3_t` encoding.
- `a`  in  32  rs1 operand (dividend / multiplicand).
- `b`  in  32  rs2 operand (divisor / multiplier).
- `flush`  in  1  abort the in-flight operation (branch mispredict or trap).
- `ready`  out  1  high only in IDLE; unit can accept `start`.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  final value; holds until the next accepted `start`.

## Operation
- FSM states:
  - IDLE: `ready`=1.
    - `start` & !`flush` latches `funct3` and operand magnitudes and records the result sign.
    - Then goes to BUSY with iteration counter = 0.
  - BUSY: one shift-add (mul) or restoring shift-subtract (div/rem) step per cycle.
    - Counter increments 0..31.
    - After the step with counter = 31, goes to DONE.
  - DONE: `done`=1 and `result` is driven. Goes to IDLE unconditionally.
- Sign rules:
  - mul/mulh: both operands signed.
  - mulhsu: `a` signed, `b` unsigned.
  - mulhu/divu/remu: both unsigned.
  - div/rem: both signed.
  - Magnitudes are used internally and the result is negated at the end when required.
  - Remainder takes the dividend's sign.
- Result select:
  - mul returns product[31:0].
  - mulh, mulhsu and mulhu return product[63:32].
  - div/divu return the quotient; rem/remu return the remainder.
- RISC-V special cases, fixed results:
  - Divisor 0: div/divu = 0xFFFFFFFF; rem/remu = `a`.
  - Signed overflow (`a`=0x80000000, `b`=0xFFFFFFFF): div = 0x80000000, rem = 0.
- Internal width: 64-bit product/remainder register, 32-bit multiplier/quotient register, 6-bit counter.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `result`=0, counter 0.
- Latency: `start` accepted at edge E0 → BUSY from E1 through E32 (32 steps) → DONE for one cycle after E33 (`done`=1) → IDLE after E34.
- Issue-to-done is 33 cycles. No overlap: `ready`=0 in BUSY and DONE.
- `start` while `ready`=0 is ignored; the pipeline must hold it.
- `flush` in BUSY or DONE → IDLE on the next edge, no `done` pulse, `result` unchanged.
- `flush` and `start` in the same IDLE cycle: `flush` wins and the request is dropped.
- `rst` asserted mid-operation: all state and outputs return to reset values immediately. No `done` follows.
- Operands and `funct3` may change after acceptance without effect.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined:
  - On a div/divu/rem/remu with `b`=0, IDLE goes directly to DONE with the special-case result.
  - On a mul-family op with `a`=0 or `b`=0, IDLE goes directly to DONE with `result`=0.
  - `done` pulses the cycle after acceptance (latency 1).
  - All other operations take 33 cycles.
- Undefined: every operation takes exactly 33 cycles. Special-case values are still correct, taken from the final fix-up.

## Test plan
- mul `a`=7, `b`=0xFFFFFFFD (−3) → `result`=0xFFFFFFEB with `done` exactly 33 cycles after the start edge. `ready` returns high the following cycle.
- mulh 0x80000000×0x80000000 → 0x40000000. mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. mulhsu 0xFFFFFFFF×2 → 0xFFFFFFFF.
- div 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. rem of the same operands → 0xFFFFFFFF. divu 100/7 → 14. remu 100/7 → 2.
- divu 5/0 → 0xFFFFFFFF. remu 5/0 → 5. div 0x80000000/0xFFFFFFFF → 0x80000000. rem of the same operands → 0. Latency is 1 with `MULDIV_EARLY_OUT_EN` and 33 without.
- Assert `flush` at BUSY step 10 → IDLE next cycle, no `done`, `result` retains its previous value. A new start then completes correctly.
- Assert `rst` at BUSY step 20 → `ready`=1, `done`=0, `result`=0 immediately. Drive `start` in the same cycle as `flush` → request dropped, no `done` within 40 cycles.
